seven_segment_scanner: RTL
==========================

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 The block SHALL have parameter DIV_WIDTH, default 16, refresh divider width; the digit slot lasts 2^DIV_WIDTH clocks.
REQ-003 The block SHALL have parameter PWM_WIDTH, default 4, brightness resolution (legal 1..DIV_WIDTH).
REQ-004 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port num_in  input  4*NUM_DIGITS  hex nibbles; nibble k drives digit k.
REQ-007 The block SHALL have port dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 The block SHALL have port load  input  1  single-cycle strobe capturing num_in/dp_in into the pending register.
REQ-009 The block SHALL have port brightness  input  PWM_WIDTH  on-time; 0 = dark.
REQ-010 The block SHALL have port dig  output  7  segments, active-low, bit0=A top, bit1=B, bit2=C, bit3=D, bit4=E, bit5=F, bit6=G middle.
REQ-011 The block SHALL have port dp  output  1  decimal point, active-low.
REQ-012 The block SHALL have port dig_sel  output  NUM_DIGITS  one-hot active-high digit enable, or all zero.
REQ-013 The block SHALL have port scan_tick  output  1  one-cycle pulse on every slot advance.

Function
REQ-014 The block SHALL run a DIV_WIDTH-bit free counter incrementing every clock and wrapping from all-ones to 0.
REQ-015 The block SHALL advance a digit index on the cycle the counter is all-ones, wrapping NUM_DIGITS-1 -> 0.
REQ-016 The block SHALL assert scan_tick, registered, in the cycle after each index advance.
REQ-017 The block SHALL capture num_in/dp_in into pending on load=1, and commit pending to active only when the index wraps to 0.
REQ-018 On load coinciding with the wrap cycle, the block SHALL commit the old pending value, hold the newly loaded value in pending, and commit it at the following wrap.
REQ-019 The block SHALL decode active nibble k to hex glyphs 0-9,A,b,C,d,E,F (0=1000000, 1=1111001, 8=0000000, F=0001110, A=0001000).
REQ-020 The block SHALL take PWM phase from counter bits [DIV_WIDTH-1 -: PWM_WIDTH]; the slot is lit when phase < brightness.
REQ-021 Lit: dig_sel = one-hot(index), dig = glyph, dp = ~active_dp[index].
REQ-022 Unlit: dig_sel = 0, dig = 7'b1111111, dp = 1.
REQ-023 All outputs SHALL be registered, valid one clock after the counter/index state they reflect.
REQ-024 A brightness change SHALL take effect on the next clock, with no mid-slot glitch beyond one cycle.

Reset
REQ-025 While rst=1: counter=0, index=0, pending=0, active=0, dig_sel=0, dig=7'b1111111, dp=1, scan_tick=0.
REQ-026 A load in flight at reset SHALL be discarded; the first lit output after release SHALL show digit 0 with value 0.

Configuration
REQ-027 With SEVEN_SEG_ZERO_BLANK_EN defined, the block SHALL blank leading zeros: any digit above the highest nonzero active nibble shows dig=7'b1111111, with dp still per dp_in; digit 0 is always shown.
REQ-028 Without SEVEN_SEG_ZERO_BLANK_EN, the block SHALL display every digit, including leading zeros.

Verification (NUM_DIGITS=4, DIV_WIDTH=4, PWM_WIDTH=2)
REQ-029 Bench: num_in=16'h12AF, load, brightness=3 -> after the next wrap, dig_sel cycles 0001,0010,0100,1000 every 16 clocks, showing F,A,2,1, with scan_tick pulsed per slot.
REQ-030 Bench: brightness=1 -> dig_sel nonzero for 4 of 16 clocks per slot; brightness=0 -> dig_sel=0, dig=7F always.
REQ-031 Bench: load 16'h0001 mid-frame -> old value shown until index wraps to 0, then new value with no torn frame.
REQ-032 Bench: load asserted exactly on the wrap cycle -> new value appears one full frame later (64 clocks).
REQ-033 Bench: assert rst mid-slot -> outputs go to reset values immediately without a clock; after release digit 0 shows 0.
REQ-034 Bench: num_in=16'h0030, dp_in=4'b1000, SEVEN_SEG_ZERO_BLANK_EN defined -> digit3 segments blank with dp=0, digit2 blank, digits 1,0 show 3,0; without the macro, digit3 shows 0.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner: hex decode, per-slot PWM brightness, frame-atomic updates.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_ZERO_BLANK_EN.
module seven_segment_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_WIDTH  = 16,
    parameter int PWM_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] num_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic [PWM_WIDTH-1:0]    brightness,
    output logic [6:0]              dig,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    scan_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_WIDTH-1:0]    cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] pending_num, active_num;
    logic [NUM_DIGITS-1:0]   pending_dp, active_dp;

    logic                  slot_end, frame_end;
    logic                  lit, cur_dp, blank;
    logic [3:0]            cur_nib;
    logic [NUM_DIGITS-1:0] sel_onehot, show;

    assign slot_end  = &cnt;
    assign frame_end = slot_end && (idx == LAST_IDX);

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        unique case (n)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    // Select the current digit's nibble, dp request and enable line.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        cur_nib    = '0;
        cur_dp     = 1'b0;
        sel_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib       = active_num[4*k +: 4];
                cur_dp        = active_dp[k];
                sel_onehot[k] = 1'b1;
            end
        end
    end

`ifdef SEVEN_SEG_ZERO_BLANK_EN
    // A digit is shown if it or any higher digit is nonzero; digit 0 always shows.
    always_comb begin
        logic seen;
        seen = 1'b0;
        show = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen    = seen | (active_num[4*k +: 4] != 4'h0);
            show[k] = seen | (k == 0);
        end
    end
`else
    assign show = '1;
`endif

    always_comb begin
        blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) blank = ~show[k];
        end
    end

    assign lit = (cnt[DIV_WIDTH-1 -: PWM_WIDTH] < brightness);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            pending_num <= '0;
            pending_dp  <= '0;
            active_num  <= '0;
            active_dp   <= '0;
            dig_sel     <= '0;
            dig         <= 7'b1111111;
            dp          <= 1'b1;
            scan_tick   <= 1'b0;
        end else begin
            cnt       <= cnt + 1'b1;
            scan_tick <= slot_end;
            if (slot_end) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;

            // A load on the wrap cycle lands in pending after the old pending commits.
            if (load) begin
                pending_num <= num_in;
                pending_dp  <= dp_in;
            end
            if (frame_end) begin
                active_num <= pending_num;
                active_dp  <= pending_dp;
            end

            if (lit) begin
                dig_sel <= sel_onehot;
                dig     <= blank ? 7'b1111111 : hex_glyph(cur_nib);
                dp      <= ~cur_dp;
            end else begin
                dig_sel <= '0;
                dig     <= 7'b1111111;
                dp      <= 1'b1;
            end
        end
    end

endmodule
